// File: rtl/fis_agg_pkg.sv
// Shared definitions for the multi-channel RX FIS aggregator: header magic,
// default error-frame payload and the arbiter state encoding.
package fis_agg_pkg;

  localparam logic [7:0]  HDR_MAGIC        = 8'hA5;
  localparam logic [31:0] ERR_WORD_DEFAULT = 32'hEEEEEEEE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } arb_state_t;

  function automatic logic [31:0] hdr_word(input logic [7:0] ch);
    return {HDR_MAGIC, ch, 16'h0000};
  endfunction

endpackage

// File: rtl/fis_frame_fifo.sv
// Per-channel frame FIFO: write/commit/read pointers, overflow dropping,
// error-frame substitution and a registered single-read-port RAM.
module fis_frame_fifo
  import fis_agg_pkg::*;
#(
  parameter int          AW       = 12,
  parameter logic [31:0] ERR_WORD = ERR_WORD_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_tvalid,
  input  logic          in_tlast,
  input  logic [31:0]   in_tdata,
  input  logic          in_err,
  input  logic          rd_en,
  output logic [31:0]   rd_data,
  output logic [AW:0]   cp,
  output logic [AW:0]   rp,
  output logic          drop_pulse
);

  localparam int DEPTH = 1 << AW;

  logic [31:0]   mem [DEPTH];
  logic [AW:0]   wp;
  logic [AW:0]   wp_n;
  logic [AW:0]   cp_n;
  logic          dropping;
  logic          dropping_n;
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic [AW:0]   depth_p;
  logic          full;
  logic          err_room;

  assign depth_p  = {1'b1, {AW{1'b0}}};
  assign full     = (wp - rp) == depth_p;
  // Room for the error word is judged after the partial frame is discarded.
  assign err_room = (cp - rp) != depth_p;

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    wp_n       = wp;
    cp_n       = cp;
    dropping_n = dropping;
    we         = 1'b0;
    waddr      = wp[AW-1:0];
    wdata      = in_tdata;
    drop_pulse = 1'b0;
    if (in_err) begin
      dropping_n = 1'b0;
      wp_n       = cp;
      if (err_room) begin
        we    = 1'b1;
        waddr = cp[AW-1:0];
        wdata = ERR_WORD;
        wp_n  = cp + 1'b1;
        cp_n  = cp + 1'b1;
      end else begin
        drop_pulse = 1'b1;
      end
    end else if (in_tvalid) begin
      if (dropping) begin
        if (in_tlast) begin
          dropping_n = 1'b0;
          drop_pulse = 1'b1;
        end
      end else if (full) begin
        wp_n = cp;
        if (in_tlast) drop_pulse = 1'b1;
        else          dropping_n = 1'b1;
      end else begin
        we   = 1'b1;
        wp_n = wp + 1'b1;
        if (in_tlast) cp_n = wp + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp       <= '0;
      cp       <= '0;
      rp       <= '0;
      dropping <= 1'b0;
    end else begin
      wp       <= wp_n;
      cp       <= cp_n;
      dropping <= dropping_n;
      if (rd_en) rp <= rp + 1'b1;
    end
  end

  // NOTE: the RAM and its read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (we)    mem[waddr] <= wdata;
    if (rd_en) rd_data    <= mem[rp[AW-1:0]];
  end

endmodule

// File: rtl/fis_rx_aggregator.sv
// Merges CHANNELS RX FIS streams round-robin into one AXI-stream, whole frames only.
// Define FIS_AGG_HEADER_EN to prefix each frame with {A5, channel, 0000}.
module fis_rx_aggregator
  import fis_agg_pkg::*;
#(
  parameter int          CHANNELS = 2,
  parameter int          FIFO_AW  = 12,
  parameter logic [31:0] ERR_WORD = ERR_WORD_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CHANNELS-1:0]     in_tvalid,
  input  logic [CHANNELS-1:0]     in_tlast,
  input  logic [32*CHANNELS-1:0]  in_tdata,
  input  logic [CHANNELS-1:0]     in_err,
  output logic                    out_tvalid,
  input  logic                    out_tready,
  output logic                    out_tlast,
  output logic [31:0]             out_tdata,
  output logic [16*CHANNELS-1:0]  drop_cnt
);

  localparam int            GW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [GW-1:0] LAST_CH = GW'(CHANNELS - 1);

  logic [FIFO_AW:0]    cp_v      [CHANNELS];
  logic [FIFO_AW:0]    rp_v      [CHANNELS];
  logic [31:0]         rd_data_v [CHANNELS];
  logic [CHANNELS-1:0] rd_en_v;
  logic [CHANNELS-1:0] drop_pulse;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [15:0] cnt;

    fis_frame_fifo #(
      .AW       (FIFO_AW),
      .ERR_WORD (ERR_WORD)
    ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .in_tvalid  (in_tvalid[c]),
      .in_tlast   (in_tlast[c]),
      .in_tdata   (in_tdata[32*c +: 32]),
      .in_err     (in_err[c]),
      .rd_en      (rd_en_v[c]),
      .rd_data    (rd_data_v[c]),
      .cp         (cp_v[c]),
      .rp         (rp_v[c]),
      .drop_pulse (drop_pulse[c])
    );

    // Saturates so a long error burst cannot wrap back to a small count.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                  cnt <= '0;
      else if (drop_pulse[c] && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    end

    assign drop_cnt[16*c +: 16] = cnt;
  end

  arb_state_t       state;
  logic [GW-1:0]    grant;
  logic [GW-1:0]    last_grant;
  logic [FIFO_AW:0] end_ptr;
  logic             q_valid;
  logic             q_last;
  logic [31:0]      q_data;

  logic             scan_hit;
  logic [GW-1:0]    scan_ch;
  logic [GW-1:0]    rd_ch;
  logic [FIFO_AW:0] rd_rp;
  logic [FIFO_AW:0] issue_end;
  logic             remaining;
  logic             rd_en;
  logic             q_move;
  logic             out_free;

  // Round-robin search starting just after the previous grant.
  always_comb begin
    scan_hit = 1'b0;
    scan_ch  = last_grant;
    for (int i = 1; i <= CHANNELS; i++) begin
      int            idx;
      logic [GW-1:0] ci;
      idx = int'(last_grant) + i;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      ci = GW'(idx);
      if (!scan_hit && cp_v[ci] != rp_v[ci]) begin
        scan_hit = 1'b1;
        scan_ch  = ci;
      end
    end
  end

  assign out_free = !out_tvalid || out_tready;
  assign q_data   = rd_data_v[grant];

  // The RAM output register plus q_valid acts as the skid word: a read is
  // issued only when that word is empty or leaves for the output this cycle.
  always_comb begin
    rd_ch     = (state == ST_IDLE) ? scan_ch : grant;
    rd_rp     = rp_v[rd_ch];
    issue_end = (state == ST_IDLE) ? cp_v[scan_ch] : end_ptr;
    remaining = rd_rp != issue_end;
    q_move    = 1'b0;
    rd_en     = 1'b0;
    case (state)
      ST_IDLE: rd_en = scan_hit;
`ifdef FIS_AGG_HEADER_EN
      ST_HDR: begin
        q_move = q_valid && out_tvalid && out_tready;
        rd_en  = remaining && (!q_valid || q_move);
      end
`endif
      ST_DATA: begin
        q_move = q_valid && out_free;
        rd_en  = remaining && (!q_valid || q_move);
      end
      default: ;
    endcase
  end

  assign rd_en_v = rd_en ? (CHANNELS'(1) << rd_ch) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= LAST_CH;
      end_ptr    <= '0;
      q_valid    <= 1'b0;
      q_last     <= 1'b0;
      out_tvalid <= 1'b0;
      out_tlast  <= 1'b0;
      out_tdata  <= '0;
    end else begin
      if (rd_en) begin
        q_valid <= 1'b1;
        q_last  <= (rd_rp + 1'b1) == issue_end;
      end else if (q_move) begin
        q_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (scan_hit) begin
            grant      <= scan_ch;
            last_grant <= scan_ch;
            // Frame end is frozen here; later commits wait for the next scan.
            end_ptr    <= cp_v[scan_ch];
`ifdef FIS_AGG_HEADER_EN
            state      <= ST_HDR;
`else
            state      <= ST_DATA;
`endif
          end
        end
`ifdef FIS_AGG_HEADER_EN
        ST_HDR: begin
          if (!out_tvalid) begin
            out_tvalid <= 1'b1;
            out_tlast  <= 1'b0;
            out_tdata  <= hdr_word(8'(grant));
          end else if (out_tready) begin
            state      <= ST_DATA;
            out_tvalid <= q_valid;
            if (q_valid) begin
              out_tdata <= q_data;
              out_tlast <= q_last;
            end
          end
        end
`endif
        ST_DATA: begin
          if (q_move) begin
            out_tvalid <= 1'b1;
            out_tdata  <= q_data;
            out_tlast  <= q_last;
          end else if (out_tvalid && out_tready) begin
            out_tvalid <= 1'b0;
            out_tlast  <= 1'b0;
            if (out_tlast) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
